// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared constants and types for the two-port RAM arbiter
package ram_arbiter_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    RDWAIT
  } state_e;

  typedef struct packed {
    logic                  write;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } req_t;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// rtl/ram_arbiter_rr_arb2.sv - two-way round-robin grant with a one-bit last-grant pointer
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid_i,
  input  logic       enable_i,
  output logic [1:0] grant_o
);

  logic last_grant_d, last_grant_q;

  always_comb begin
    grant_o = 2'b00;
    if (enable_i) begin
      case (valid_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        // Contention goes to whoever did not win last time
        2'b11:   grant_o = last_grant_q ? 2'b01 : 2'b10;
        default: grant_o = 2'b00;
      endcase
    end
    last_grant_d = (grant_o != 2'b00) ? grant_o[1] : last_grant_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester round-robin sequencer for the 1024x8 single-port RAM
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_0,
  input  logic              req_write_0,
  input  logic [ADDR_W-1:0] req_addr_0,
  input  logic [DATA_W-1:0] req_wdata_0,
  output logic              req_ready_0,
  output logic              rsp_valid_0,
  output logic [DATA_W-1:0] rsp_rdata_0,
  input  logic              req_valid_1,
  input  logic              req_write_1,
  input  logic [ADDR_W-1:0] req_addr_1,
  input  logic [DATA_W-1:0] req_wdata_1,
  output logic              req_ready_1,
  output logic              rsp_valid_1,
  output logic [DATA_W-1:0] rsp_rdata_1,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_cs,
  output logic              ram_wr,
  output logic              ram_rd,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              busy
);

  state_e            state_q;
  logic              owner_q;
  logic              write_q;
  logic [1:0]        grant;
  logic [1:0]        rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_0_q, rsp_rdata_1_q;
  logic [ADDR_W-1:0] ram_address_q;
  logic [DATA_W-1:0] ram_data_in_q;
  logic              ram_cs_q, ram_wr_q, ram_rd_q;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst      (rst),
    .valid_i  ({req_valid_1, req_valid_0}),
    .enable_i ((state_q == IDLE) && !rst),
    .grant_o  (grant)
  );

  assign req_ready_0 = grant[0];
  assign req_ready_1 = grant[1];

  always_comb begin
    sel_write = grant[1] ? req_write_1 : req_write_0;
    sel_addr  = grant[1] ? req_addr_1  : req_addr_0;
    sel_wdata = grant[1] ? req_wdata_1 : req_wdata_0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      write_q       <= 1'b0;
      ram_address_q <= '0;
      ram_data_in_q <= '0;
      ram_cs_q      <= 1'b0;
      ram_wr_q      <= 1'b0;
      ram_rd_q      <= 1'b0;
      rsp_valid_q   <= 2'b00;
      rsp_rdata_0_q <= '0;
      rsp_rdata_1_q <= '0;
    end else begin
      ram_cs_q    <= 1'b0;
      ram_wr_q    <= 1'b0;
      ram_rd_q    <= 1'b0;
      rsp_valid_q <= 2'b00;
      case (state_q)
        IDLE: begin
          // Strobes are loaded with the command so they are live for the whole CMD cycle
          if (grant != 2'b00) begin
            state_q       <= CMD;
            owner_q       <= grant[1];
            write_q       <= sel_write;
            ram_address_q <= sel_addr;
            ram_data_in_q <= sel_wdata;
            ram_cs_q      <= 1'b1;
            ram_wr_q      <= sel_write;
            ram_rd_q      <= !sel_write;
          end
        end
        CMD: begin
          state_q <= write_q ? IDLE : RDWAIT;
        end
        RDWAIT: begin
          state_q              <= IDLE;
          rsp_valid_q[owner_q] <= 1'b1;
          if (owner_q) begin
            rsp_rdata_1_q <= ram_data_out;
          end else begin
            rsp_rdata_0_q <= ram_data_out;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_address = ram_address_q;
  assign ram_data_in = ram_data_in_q;
  assign ram_cs      = ram_cs_q;
  assign ram_wr      = ram_wr_q;
  assign ram_rd      = ram_rd_q;
  assign rsp_valid_0 = rsp_valid_q[0];
  assign rsp_valid_1 = rsp_valid_q[1];
  assign rsp_rdata_0 = rsp_rdata_0_q;
  assign rsp_rdata_1 = rsp_rdata_1_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter against a transaction-level model
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       v [2];
  logic       w [2];
  logic [9:0] ad [2];
  logic [7:0] wd [2];

  logic       req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1;
  logic [7:0] rsp_rdata_0, rsp_rdata_1;
  logic [9:0] ram_address;
  logic [7:0] ram_data_in, ram_dout;
  logic       ram_cs, ram_wr, ram_rd, busy;
  logic [1:0] rdy;
  assign rdy = {req_ready_1, req_ready_0};

  ram_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_0  (v[0]),
    .req_write_0  (w[0]),
    .req_addr_0   (ad[0]),
    .req_wdata_0  (wd[0]),
    .req_ready_0  (req_ready_0),
    .rsp_valid_0  (rsp_valid_0),
    .rsp_rdata_0  (rsp_rdata_0),
    .req_valid_1  (v[1]),
    .req_write_1  (w[1]),
    .req_addr_1   (ad[1]),
    .req_wdata_1  (wd[1]),
    .req_ready_1  (req_ready_1),
    .rsp_valid_1  (rsp_valid_1),
    .rsp_rdata_1  (rsp_rdata_1),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_cs       (ram_cs),
    .ram_wr       (ram_wr),
    .ram_rd       (ram_rd),
    .ram_data_out (ram_dout),
    .busy         (busy)
  );

  // Single-port RAM with registered read data and no reset
  logic [7:0] mem [1024] = '{default: 8'h00};
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_wr) mem[ram_address] <= ram_data_in;
      if (ram_rd) ram_dout <= mem[ram_address];
    end
  end

  typedef struct {int due; req_t r;} cmd_t;
  typedef struct {int due; logic [7:0] d;} rsp_t;

  cmd_t       cmdq [$];
  rsp_t       rsp0 [$];
  rsp_t       rsp1 [$];
  int         grant_log [$];
  int         acc_cyc [$];
  logic [7:0] shadow [1024] = '{default: 8'h00};
  logic [7:0] last_rd [2] = '{8'h00, 8'h00};
  logic [9:0] exp_addr = '0;
  logic [7:0] exp_din = '0;
  int         cd = 0;
  logic       model_last = 1'b1;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Model: one request in service at a time; a write occupies 1 busy cycle, a read 2
  logic       idle, due;
  logic [1:0] exp_rdy;
  logic [2:0] exp_str;
  int         win;
  cmd_t       ce;
  rsp_t       re;

  always @(negedge clk) begin
    idle = (cd == 0);
    chk("busy", 32'(busy), 32'(!idle));
    exp_rdy = 2'b00;
    win = 0;
    if (!rst && idle && (v[0] || v[1])) begin
      if (v[0] && v[1]) win = model_last ? 0 : 1;
      else win = v[1] ? 1 : 0;
      exp_rdy[win] = 1'b1;
    end
    chk("req_ready", 32'(rdy), 32'(exp_rdy));

    due = (cmdq.size() > 0) && (cmdq[0].due == cyc);
    exp_str = 3'b000;
    if (due) begin
      ce = cmdq.pop_front();
      exp_str = {1'b1, ce.r.write, !ce.r.write};
      exp_addr = ce.r.addr;
      exp_din = ce.r.wdata;
    end
    chk("strobes", 32'({ram_cs, ram_wr, ram_rd}), 32'(exp_str));
    chk("ram_address", 32'(ram_address), 32'(exp_addr));
    chk("ram_data_in", 32'(ram_data_in), 32'(exp_din));

    due = (rsp0.size() > 0) && (rsp0[0].due == cyc);
    if (due) begin
      re = rsp0.pop_front();
      last_rd[0] = re.d;
    end
    chk("rsp_valid_0", 32'(rsp_valid_0), 32'(due));
    chk("rsp_rdata_0", 32'(rsp_rdata_0), 32'(last_rd[0]));
    due = (rsp1.size() > 0) && (rsp1[0].due == cyc);
    if (due) begin
      re = rsp1.pop_front();
      last_rd[1] = re.d;
    end
    chk("rsp_valid_1", 32'(rsp_valid_1), 32'(due));
    chk("rsp_rdata_1", 32'(rsp_rdata_1), 32'(last_rd[1]));

    if (!idle) begin
      cd = cd - 1;
    end else if (exp_rdy != 2'b00) begin
      ce.due = cyc + 1;
      ce.r.write = w[win];
      ce.r.addr = ad[win];
      ce.r.wdata = wd[win];
      cmdq.push_back(ce);
      if (w[win]) begin
        shadow[ad[win]] = wd[win];
        cd = 1;
      end else begin
        re.due = cyc + 3;
        re.d = shadow[ad[win]];
        if (win == 0) rsp0.push_back(re);
        else rsp1.push_back(re);
        cd = 2;
      end
      model_last = (win == 1);
    end

    if (rst) begin
      cd = 0;
      model_last = 1'b1;
      cmdq.delete();
      rsp0.delete();
      rsp1.delete();
      last_rd[0] = 8'h00;
      last_rd[1] = 8'h00;
      exp_addr = '0;
      exp_din = '0;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic issue(input int i, input logic wr_i, input logic [9:0] a, input logic [7:0] d);
    int n;
    n = 0;
    v[i] = 1'b1;
    w[i] = wr_i;
    ad[i] = a;
    wd[i] = d;
    do begin
      @(negedge clk);
      n++;
    end while (!(rdy[i] && v[i]) && n < 40);
    chk("accept_in_time", 32'(n < 40), 32'd1);
    if (n < 40) begin
      grant_log.push_back(i);
      acc_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1 v[i] = 1'b0;
  endtask

  function automatic logic [9:0] pick_addr();
    int r;
    r = $urandom_range(0, 8);
    return (r == 8) ? 10'h3FF : 10'(r);
  endfunction

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; w[i] = 1'b0; ad[i] = '0; wd[i] = '0;
    end
    idle_cycles(3);
    rst = 1'b0;

    issue(0, 1'b1, 10'h3FF, 8'hA5);
    idle_cycles(2);
    issue(1, 1'b0, 10'h3FF, 8'h00);
    idle_cycles(3);
    issue(0, 1'b1, 10'h001, 8'h11);
    issue(0, 1'b1, 10'h002, 8'h22);
    // Reset lands on the edge that ends this write's CMD cycle
    rst = 1'b1;
    idle_cycles(1);
    rst = 1'b0;

    grant_log.delete();
    fork
      begin
        for (int k = 0; k < 4; k++) issue(0, 1'b0, 10'h001, 8'(k));
      end
      begin
        for (int k = 0; k < 4; k++) issue(1, 1'b0, 10'h002, 8'(k));
      end
    join
    chk("rr_count", 32'(grant_log.size()), 32'd8);
    for (int k = 0; k < 8 && k < grant_log.size(); k++) chk("rr_order", 32'(grant_log[k]), 32'(k % 2));

    acc_cyc.delete();
    for (int k = 0; k < 3; k++) issue(1, 1'b1, 10'h010 + 10'(k), 8'($urandom));
    chk("wr_gap_a", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);
    chk("wr_gap_b", 32'(acc_cyc[2] - acc_cyc[1]), 32'd2);

    grant_log.delete();
    fork
      issue(0, 1'b0, 10'h010, 8'h00);
      issue(1, 1'b0, 10'h011, 8'h00);
    join
    chk("first_after_r1_writes", 32'(grant_log[0]), 32'd0);

    issue(0, 1'b0, 10'h3FF, 8'h00);
    idle_cycles(1);
    rst = 1'b1;
    fork
      begin
        @(posedge clk);
        #1 rst = 1'b0;
      end
    join_none
    acc_cyc.delete();
    issue(0, 1'b0, 10'h001, 8'h00);
    idle_cycles(3);

    fork
      begin
        for (int k = 0; k < 25; k++) begin
          idle_cycles($urandom_range(0, 2));
          issue(0, 1'($urandom_range(0, 1)), pick_addr(), 8'($urandom));
        end
      end
      begin
        for (int k = 0; k < 25; k++) begin
          idle_cycles($urandom_range(0, 2));
          issue(1, 1'($urandom_range(0, 1)), pick_addr(), 8'($urandom));
        end
      end
    join
    idle_cycles(6);
    chk("cmdq_drained", 32'(cmdq.size()), 32'd0);
    chk("rsp0_drained", 32'(rsp0.size()), 32'd0);
    chk("rsp1_drained", 32'(rsp1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary line");
    $fatal(1);
  end

endmodule
